// File: rtl/pet_prg_loader.sv
// rtl/pet_prg_loader.sv - PRG image loader driving the PET DMA write port
//
// Turns a host byte stream holding a Commodore PRG image into RAM writes.
// The first two stream bytes are the little-endian load address. When the
// image has been written, the BASIC 4 VARTAB/ARYTAB/STREND pointers are set
// to the end of the image, so RUN works straight away.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   dl_active         download window; rising edge starts, falling edge ends
//   dl_wr, dl_data    one-cycle byte strobe and stream byte
//   dl_wait           high during the pointer patch writes
//   dma_addr/din/we   registered RAM write port
//   cpu_hold          holds the CPU in reset while a load is in progress
//   err               sticky: short header or byte outside RAM
module pet_prg_loader #(
    parameter int          PATCH_BASIC = 1,
    parameter logic [15:0] PTR_BASE    = 16'h002A,
    parameter logic [15:0] RAM_TOP     = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        cpu_hold,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_PATCH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        dl_active_q;
    logic [15:0] ptr_q, ptr_d;
    logic        ovf_q, ovf_d;
    logic [2:0]  patch_idx_q, patch_idx_d;
    logic        err_q, err_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        dl_wait_q, dl_wait_d;
    logic        dma_we_q, dma_we_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic [7:0]  dma_din_q, dma_din_d;

    logic        act_rise;
    logic        act_fall;
    logic        in_range;
    logic [15:0] patch_addr;

    assign act_rise   = dl_active & ~dl_active_q;
    assign act_fall   = ~dl_active & dl_active_q;
    // Once the pointer has left RAM, bytes stay discarded even after the
    // 16-bit pointer wraps back into low memory.
    assign in_range   = ~ovf_q && (ptr_q < RAM_TOP) && ~ptr_q[15];
    assign patch_addr = PTR_BASE + {13'd0, patch_idx_q};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        patch_idx_d = patch_idx_q;
        err_d       = err_q;
        cpu_hold_d  = cpu_hold_q;
        dl_wait_d   = 1'b0;
        dma_we_d    = 1'b0;
        dma_addr_d  = dma_addr_q;
        dma_din_d   = dma_din_q;

        case (state_q)
            S_IDLE: begin
                if (act_rise) begin
                    err_d      = 1'b0;
                    ovf_d      = 1'b0;
                    cpu_hold_d = 1'b1;
                    state_d    = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (dl_wr) begin
                    ptr_d[7:0] = dl_data;
                    state_d    = S_HDR_HI;
                end
                if (act_fall) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_HDR_HI: begin
                if (dl_wr) begin
                    ptr_d[15:8] = dl_data;
                    state_d     = S_DATA;
                    // Header completed on the closing cycle: empty image.
                    if (act_fall) begin
                        patch_idx_d = 3'd0;
                        state_d     = (PATCH_BASIC != 0) ? S_PATCH : S_DONE;
                    end
                end else if (act_fall) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DATA: begin
                if (dl_wr) begin
                    if (in_range) begin
                        dma_we_d   = 1'b1;
                        dma_addr_d = ptr_q;
                        dma_din_d  = dl_data;
                    end else begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end
                    ptr_d = ptr_q + 16'd1;
                end
                // err_d already reflects a bad byte arriving on this cycle.
                if (act_fall) begin
                    patch_idx_d = 3'd0;
                    state_d     = ((PATCH_BASIC != 0) && !err_d) ? S_PATCH : S_DONE;
                end
            end
            S_PATCH: begin
                dl_wait_d  = 1'b1;
                dma_we_d   = ~patch_addr[15];
                dma_addr_d = patch_addr;
                dma_din_d  = patch_idx_q[0] ? ptr_q[15:8] : ptr_q[7:0];
                if (patch_idx_q == 3'd5) begin
                    state_d = S_DONE;
                end else begin
                    patch_idx_d = patch_idx_q + 3'd1;
                end
            end
            S_DONE: begin
                cpu_hold_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            // Track the live level so a reset inside a download does not
            // look like a fresh start edge afterwards.
            dl_active_q <= dl_active;
            ptr_q       <= 16'd0;
            ovf_q       <= 1'b0;
            patch_idx_q <= 3'd0;
            err_q       <= 1'b0;
            cpu_hold_q  <= 1'b0;
            dl_wait_q   <= 1'b0;
            dma_we_q    <= 1'b0;
            dma_addr_q  <= 16'd0;
            dma_din_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            dl_active_q <= dl_active;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            patch_idx_q <= patch_idx_d;
            err_q       <= err_d;
            cpu_hold_q  <= cpu_hold_d;
            dl_wait_q   <= dl_wait_d;
            dma_we_q    <= dma_we_d;
            dma_addr_q  <= dma_addr_d;
            dma_din_q   <= dma_din_d;
        end
    end

    assign dl_wait  = dl_wait_q;
    assign dma_addr = dma_addr_q;
    assign dma_din  = dma_din_q;
    assign dma_we   = dma_we_q;
    assign cpu_hold = cpu_hold_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pet_prg_loader.sv
// tb/tb_pet_prg_loader.sv - directed testbench for pet_prg_loader
module tb_pet_prg_loader;

    logic        clk;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        cpu_hold;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wait_cnt;
    int          wait_bad;

    pet_prg_loader dut (
        .clk      (clk),
        .reset    (reset),
        .dl_active(dl_active),
        .dl_wr    (dl_wr),
        .dl_data  (dl_data),
        .dl_wait  (dl_wait),
        .dma_addr (dma_addr),
        .dma_din  (dma_din),
        .dma_we   (dma_we),
        .cpu_hold (cpu_hold),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dma_we) begin
            wr_addr.push_back(dma_addr);
            wr_data.push_back(dma_din);
        end
        if (dl_wait) wait_cnt++;
        if (dl_wait && !dma_we) wait_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wait_cnt = 0;
        wait_bad = 0;
    endtask

    task automatic start_load();
        dl_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        dl_wr   = 1'b1;
        dl_data = b;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic send_last(input logic [7:0] b);
        dl_wr     = 1'b1;
        dl_data   = b;
        dl_active = 1'b0;
        tick();
        dl_wr     = 1'b0;
    endtask

    task automatic end_load();
        dl_active = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (cpu_hold && n < 30) begin
            tick();
            n++;
        end
        tick();
        tick();
        total++;
        if (n >= 30) begin
            bad++;
            $display("FAIL %s_timeout: cpu_hold still %0b after %0d cycles, need 0", name, cpu_hold, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total++;
        if ({dma_we, dma_addr, dma_din, dl_wait, cpu_hold, err} !== 28'd0) begin
            bad++;
            $display("FAIL reset_state: we=%0b addr=%h din=%h wait=%0b hold=%0b err=%0b, need all 0",
                     dma_we, dma_addr, dma_din, dl_wait, cpu_hold, err);
        end
    endtask

    task automatic test_basic();
        logic [23:0] exp[8] = '{24'h0401A9, 24'h040200, 24'h002A03, 24'h002B04,
                                24'h002C03, 24'h002D04, 24'h002E03, 24'h002F04};
        clear_log();
        start_load();
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold_high: cpu_hold=%0b, need 1", cpu_hold);
        end
        send(8'h01);
        send(8'h04);
        send(8'hA9);
        total++;
        if ({dma_we, dma_addr, dma_din} !== 25'h1_0401_A9) begin
            bad++;
            $display("FAIL basic_latency: we=%0b addr=%h din=%h, need 1 0401 a9", dma_we, dma_addr, dma_din);
        end
        send(8'h00);
        end_load();
        wait_idle("basic");
        total++;
        if (wr_addr.size() != 8) begin
            bad++;
            $display("FAIL basic_count: %0d writes, need 8", wr_addr.size());
        end
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            total++;
            if ({wr_addr[i], wr_data[i]} !== exp[i]) begin
                bad++;
                $display("FAIL basic_wr%0d: got %h=%h, need %h", i, wr_addr[i], wr_data[i], exp[i]);
            end
        end
        total++;
        if (wait_cnt != 6 || wait_bad != 0) begin
            bad++;
            $display("FAIL basic_dl_wait: %0d wait cycles (%0d without write), need 6 (0)", wait_cnt, wait_bad);
        end
        total++;
        if (err !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL basic_end: err=%0b hold=%0b, need 0 0", err, cpu_hold);
        end
    endtask

    task automatic test_header_only();
        logic [23:0] exp[6] = '{24'h002A00, 24'h002B10, 24'h002C00,
                                24'h002D10, 24'h002E00, 24'h002F10};
        clear_log();
        start_load();
        send(8'h00);
        send(8'h10);
        end_load();
        wait_idle("hdr_only");
        total++;
        if (wr_addr.size() != 6) begin
            bad++;
            $display("FAIL hdr_only_count: %0d writes, need 6", wr_addr.size());
        end
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            total++;
            if ({wr_addr[i], wr_data[i]} !== exp[i]) begin
                bad++;
                $display("FAIL hdr_only_wr%0d: got %h=%h, need %h", i, wr_addr[i], wr_data[i], exp[i]);
            end
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL hdr_only_err: err=%0b, need 0", err);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] exp[2] = '{24'h7FFE11, 24'h7FFF22};
        clear_log();
        start_load();
        send(8'hFE);
        send(8'h7F);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        end_load();
        wait_idle("ovf");
        total++;
        if (wr_addr.size() != 2) begin
            bad++;
            $display("FAIL ovf_count: %0d writes, need 2", wr_addr.size());
        end
        for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
            total++;
            if ({wr_addr[i], wr_data[i]} !== exp[i]) begin
                bad++;
                $display("FAIL ovf_wr%0d: got %h=%h, need %h", i, wr_addr[i], wr_data[i], exp[i]);
            end
        end
        total++;
        if (err !== 1'b1 || cpu_hold !== 1'b0 || wait_cnt != 0) begin
            bad++;
            $display("FAIL ovf_end: err=%0b hold=%0b wait_cycles=%0d, need 1 0 0", err, cpu_hold, wait_cnt);
        end
    endtask

    task automatic test_short_header();
        clear_log();
        start_load();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL short_err_cleared: err=%0b, need 0", err);
        end
        send(8'h01);
        end_load();
        wait_idle("short");
        total++;
        if (err !== 1'b1 || wr_addr.size() != 0) begin
            bad++;
            $display("FAIL short_end: err=%0b writes=%0d, need 1 0", err, wr_addr.size());
        end
    endtask

    task automatic test_coincident();
        logic [23:0] exp[8] = '{24'h2000AA, 24'h2001BB, 24'h002A02, 24'h002B20,
                                24'h002C02, 24'h002D20, 24'h002E02, 24'h002F20};
        clear_log();
        start_load();
        send(8'h00);
        send(8'h20);
        send(8'hAA);
        send_last(8'hBB);
        wait_idle("coinc");
        total++;
        if (wr_addr.size() != 8) begin
            bad++;
            $display("FAIL coinc_count: %0d writes, need 8", wr_addr.size());
        end
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            total++;
            if ({wr_addr[i], wr_data[i]} !== exp[i]) begin
                bad++;
                $display("FAIL coinc_wr%0d: got %h=%h, need %h", i, wr_addr[i], wr_data[i], exp[i]);
            end
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL coinc_err: err=%0b, need 0", err);
        end
    endtask

    task automatic test_reset_in_patch();
        logic [23:0] exp[7] = '{24'h040155, 24'h002A02, 24'h002B04, 24'h002C02,
                                24'h002D04, 24'h002E02, 24'h002F04};
        int n;
        clear_log();
        start_load();
        send(8'h00);
        send(8'h05);
        send(8'h77);
        end_load();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dma_we && dma_addr == 16'h002C) && n < 20);
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL rst_patch_reach: third patch write not seen within %0d cycles", n);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (dma_we !== 1'b0 || cpu_hold !== 1'b0 || dl_wait !== 1'b0) begin
            bad++;
            $display("FAIL rst_patch_abort: we=%0b hold=%0b wait=%0b, need 0 0 0", dma_we, cpu_hold, dl_wait);
        end
        total++;
        if (wr_addr.size() != 4) begin
            bad++;
            $display("FAIL rst_patch_partial: %0d writes before reset, need 4", wr_addr.size());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (wr_addr.size() != 4 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL rst_patch_quiet: writes=%0d hold=%0b, need 4 0", wr_addr.size(), cpu_hold);
        end
        clear_log();
        start_load();
        send(8'h01);
        send(8'h04);
        send(8'h55);
        end_load();
        wait_idle("reload");
        total++;
        if (wr_addr.size() != 7) begin
            bad++;
            $display("FAIL reload_count: %0d writes, need 7", wr_addr.size());
        end
        for (int i = 0; i < 7 && i < wr_addr.size(); i++) begin
            total++;
            if ({wr_addr[i], wr_data[i]} !== exp[i]) begin
                bad++;
                $display("FAIL reload_wr%0d: got %h=%h, need %h", i, wr_addr[i], wr_data[i], exp[i]);
            end
        end
        total++;
        if (err !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL reload_end: err=%0b hold=%0b, need 0 0", err, cpu_hold);
        end
    endtask

    initial begin
        reset     = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_data   = 8'h00;
        wait_cnt  = 0;
        wait_bad  = 0;
        test_reset();
        test_basic();
        test_header_only();
        test_overflow();
        test_short_header();
        test_coincident();
        test_reset_in_patch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
